adder_resp_checker: RTL and testbench

//  Response-side checker for full adders and N-bit ripple adders. Consumes the

---
 rtl/adder_chk_pkg.sv | 23 ++
 rtl/adder_chk_delay.sv | 74 +++++++
 rtl/adder_resp_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_adder_resp_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and golden-model helper for the adder response checker.
package adder_chk_pkg;

  // Widest operand the golden helper supports; callers truncate the result.
  localparam int unsigned ADD_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // Golden {cout,sum} of a + b + cin, carried at ADD_MAX_W+1 bits.
  function automatic logic [ADD_MAX_W:0] exp_add(
    input logic [ADD_MAX_W-1:0] a,
    input logic [ADD_MAX_W-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{ADD_MAX_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_chk_delay.sv
// Aligns accepted vectors with the DUT result: LAT-stage shift register of
// {valid, payload} with a synchronous flush. LAT = 0 is a wire.
module adder_chk_delay #(
  parameter int unsigned DW  = 4,
  parameter int unsigned LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          empty_next_c
);

  if (LAT == 0) begin : g_pass
    logic unused_dly;

    assign out_valid    = in_valid;
    assign out_data     = in_data;
    assign empty_next_c = 1'b1;
    assign unused_dly   = ^{clk, rst, flush};
  end else begin : g_pipe
    logic [LAT-1:0] valid_q;
    logic [LAT-1:0] valid_d;
    logic [DW-1:0]  data_q [LAT];
    logic [DW-1:0]  data_d [LAT];
    logic           empty_c;

    // Shift one stage per cycle; flush invalidates every stage.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = '0;
      end else begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int unsigned i = 1; i < LAT; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end

    // Pipe holds nothing after this edge: no new entry and only the
    // output stage (consumed this cycle) may be occupied.
    always_comb begin
      empty_c = !in_valid;
      for (int unsigned i = 0; i + 1 < LAT; i++) begin
        if (valid_q[i]) begin
          empty_c = 1'b0;
        end
      end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        data_q  <= '{default: '0};
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid    = valid_q[LAT-1];
    assign out_data     = data_q[LAT-1];
    assign empty_next_c = flush | empty_c;
  end

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for full adders / N-bit ripple adders: compares the DUT's
// {cout,sum} against a + b + cin, counts vectors and mismatches, and records
// the first failing vector index.
// Optional feature macro: ADDER_CHK_COVER_EN adds an operand-coverage bitmap
// ({a,b,cin} seen) and makes pass also require full coverage.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned DUT_LAT     = 0,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               vec_valid,
  input  logic [WIDTH-1:0]                   vec_a,
  input  logic [WIDTH-1:0]                   vec_b,
  input  logic                               vec_cin,
  input  logic [WIDTH-1:0]                   dut_sum,
  input  logic                               dut_cout,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [ERR_CNT_W-1:0]               err_cnt,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_cnt,
  output logic [$clog2(NUM_VECTORS)-1:0]     first_fail_idx,
  output logic                               first_fail_vld,
  output logic                               cov_full
);

  localparam int unsigned CNT_W = $clog2(NUM_VECTORS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_VECTORS);
  localparam int unsigned OP_W  = 2 * WIDTH + 1;
  localparam int unsigned DW    = IDX_W + OP_W;
  localparam int unsigned RES_W = WIDTH + 1;

  localparam logic [CNT_W-1:0]     NUM_C   = CNT_W'(NUM_VECTORS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  chk_state_e state_q, state_d;

  logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]     ffi_q, ffi_d;
  logic                 ffv_q, ffv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 cov_full_d;

  logic                 accept_c;
  logic [DW-1:0]        acc_data_c;
  logic                 dly_valid;
  logic [DW-1:0]        dly_data;
  logic                 empty_next_c;

  logic [IDX_W-1:0]     cmp_idx_c;
  logic [WIDTH-1:0]     cmp_a_c;
  logic [WIDTH-1:0]     cmp_b_c;
  logic                 cmp_cin_c;
  logic [RES_W-1:0]     exp_res_c;
  logic                 cmp_fire_c;
  logic                 mismatch_c;

  // Vector acceptance: only in RUN, only until the session quota is met,
  // and never in a start cycle.
  always_comb begin
    accept_c   = (state_q == RUN) && vec_valid && !start && (vec_cnt_q < NUM_C);
    acc_data_c = {IDX_W'(vec_cnt_q), vec_a, vec_b, vec_cin};
  end

  adder_chk_delay #(
    .DW  (DW),
    .LAT (DUT_LAT)
  ) u_delay (
    .clk          (clk),
    .rst          (rst),
    .flush        (start),
    .in_valid     (accept_c),
    .in_data      (acc_data_c),
    .out_valid    (dly_valid),
    .out_data     (dly_data),
    .empty_next_c (empty_next_c)
  );

  // Golden compare of the delayed vector against the live DUT result.
  always_comb begin
    {cmp_idx_c, cmp_a_c, cmp_b_c, cmp_cin_c} = dly_data;
    exp_res_c  = RES_W'(exp_add(ADD_MAX_W'(cmp_a_c), ADD_MAX_W'(cmp_b_c), cmp_cin_c));
    cmp_fire_c = dly_valid && !start;
    mismatch_c = cmp_fire_c && ({dut_cout, dut_sum} != exp_res_c);
  end

  // Session statistics: start clears, otherwise count accepts and mismatches.
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    ffi_d     = ffi_q;
    ffv_d     = ffv_q;
    if (start) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
      ffi_d     = '0;
      ffv_d     = 1'b0;
    end else begin
      if (accept_c) begin
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
      end
      if (mismatch_c) begin
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = cmp_idx_c;
        end
      end
    end
  end

  // Session FSM next state and registered status outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pass_d  = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        if (vec_cnt_d == NUM_C) begin
          state_d = empty_next_c ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (empty_next_c) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = RUN;
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0) && cov_full_d;
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      ffi_q     <= '0;
      ffv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      ffi_q     <= ffi_d;
      ffv_q     <= ffv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

`ifdef ADDER_CHK_COVER_EN
  localparam int unsigned COV_N = 1 << OP_W;

  logic [COV_N-1:0] seen_q, seen_d;
  logic             cov_full_q;

  if (WIDTH > 3) begin : g_width_chk
    $error("adder_resp_checker: coverage bitmap supports WIDTH <= 3");
  end

  // Mark each accepted {a,b,cin} combination; start clears the map.
  always_comb begin
    seen_d = seen_q;
    if (start) begin
      seen_d = '0;
    end else if (accept_c) begin
      seen_d[{vec_a, vec_b, vec_cin}] = 1'b1;
    end
    cov_full_d = &seen_d;
  end

  // Coverage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q     <= '0;
      cov_full_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      cov_full_q <= cov_full_d;
    end
  end

  assign cov_full = cov_full_q;
`else
  assign cov_full_d = 1'b1;
  assign cov_full   = 1'b1;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign vec_cnt        = vec_cnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Bench for adder_resp_checker: one combinational-latency 1-bit instance and
// one 3-bit, 3-cycle-latency, 2-bit error-counter instance, driven with
// random and exhaustive vectors against an arithmetic reference model.
module tb_adder_resp_checker;

  localparam int WA = 1;
  localparam int NA = 8;
  localparam int LA = 0;
  localparam int WB = 3;
  localparam int NB = 16;
  localparam int LB = 3;

`ifdef ADDER_CHK_COVER_EN
  localparam int COV_RST = 0;
`else
  localparam int COV_RST = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b, valid_a, valid_b;
  logic [2:0] a_s, b_s;
  logic       cin_s;
  logic [3:0] res_s;

  logic       busy_a, done_a, pass_a, ffv_a, cov_a;
  logic [7:0] err_a;
  logic [3:0] vcnt_a;
  logic [2:0] ffi_a;
  logic       busy_b, done_b, pass_b, ffv_b, cov_b;
  logic [1:0] err_b;
  logic [4:0] vcnt_b;
  logic [3:0] ffi_b;

  int checks = 0;
  int errors = 0;
  bit sel;

  logic       o_busy, o_done, o_pass, o_ffv, o_cov;
  logic [7:0] o_err;
  logic [4:0] o_vcnt;
  logic [3:0] o_ffi;

  adder_resp_checker #(.WIDTH(WA), .NUM_VECTORS(NA), .DUT_LAT(LA), .ERR_CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_valid(valid_a),
    .vec_a(a_s[0]), .vec_b(b_s[0]), .vec_cin(cin_s),
    .dut_sum(res_s[0]), .dut_cout(res_s[1]),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .vec_cnt(vcnt_a),
    .first_fail_idx(ffi_a), .first_fail_vld(ffv_a), .cov_full(cov_a)
  );

  adder_resp_checker #(.WIDTH(WB), .NUM_VECTORS(NB), .DUT_LAT(LB), .ERR_CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_valid(valid_b),
    .vec_a(a_s), .vec_b(b_s), .vec_cin(cin_s),
    .dut_sum(res_s[2:0]), .dut_cout(res_s[3]),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .vec_cnt(vcnt_b),
    .first_fail_idx(ffi_b), .first_fail_vld(ffv_b), .cov_full(cov_b)
  );

  always_comb begin
    if (sel) begin
      o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_ffv = ffv_b; o_cov = cov_b;
      o_err  = 8'(err_b); o_vcnt = vcnt_b; o_ffi = ffi_b;
    end else begin
      o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_ffv = ffv_a; o_cov = cov_a;
      o_err  = err_a; o_vcnt = 5'(vcnt_a); o_ffi = 4'(ffi_a);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v; else start_a = v;
  endtask

  task automatic set_valid(input bit s, input logic v);
    if (s) valid_b = v; else valid_a = v;
  endtask

  task automatic check_final(input string tag, input int busy_e, input int done_e, input int pass_e,
                             input int err_e, input int vcnt_e, input int ffv_e, input int ffi_e,
                             input int cov_e);
    chk({tag, " busy"}, 32'(o_busy), busy_e);
    chk({tag, " done"}, 32'(o_done), done_e);
    chk({tag, " pass"}, 32'(o_pass), pass_e);
    chk({tag, " err_cnt"}, 32'(o_err), err_e);
    chk({tag, " vec_cnt"}, 32'(o_vcnt), vcnt_e);
    chk({tag, " ff_vld"}, 32'(o_ffv), ffv_e);
    chk({tag, " ff_idx"}, 32'(o_ffi), ffi_e);
    chk({tag, " cov_full"}, 32'(o_cov), cov_e);
  endtask

  // Synchronous reset pulse, then both instances must be at reset values.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_final($sformatf("%s[%0d]", tag, s), 0, 0, 0, 0, 0, 0, 0, COV_RST);
    end
  endtask

  // One session: start (with a same-cycle junk vector), vectors with random
  // gaps, DUT results presented lat cycles after their operands, garbage on
  // idle cycles. mode: 0 clean, 1 random faults, 2 all faulty, 3 cout
  // dropped on vector 7, 4 all-zero operands.
  task automatic run_session(input string tag, input bit s, input int n_drive, input int mode,
                             input bit exh, input int abort_after);
    int w, lat, n, emax, drawn, last_acc, mism, exp_ffi, nseen, golden, mask, k, idx;
    bit exp_ffv, exp_cov, exp_busy;
    bit qv[100];
    logic [2:0] qa[100], qb[100];
    logic qc[100];
    logic [3:0] qr[100];
    bit seen[128];
    w = s ? WB : WA; lat = s ? LB : LA; n = s ? NB : NA; emax = s ? 3 : 255;
    sel = s; drawn = 0; last_acc = -1; mism = 0; exp_ffi = 0; exp_ffv = 0; nseen = 0;
    @(negedge clk);
    set_start(s, 1'b1); set_valid(s, 1'b1);
    a_s = 3'($urandom); b_s = 3'($urandom); cin_s = 1'($urandom); res_s = 4'($urandom);
    @(negedge clk);
    set_start(s, 1'b0);
    for (int c = 0; c < 90; c++) begin
      exp_busy = (last_acc < 0) || (c <= last_acc + lat);
      chk($sformatf("%s c%0d busy", tag, c), 32'(o_busy), 32'(exp_busy));
      chk($sformatf("%s c%0d done", tag, c), 32'(o_done), 32'(!exp_busy));
      chk($sformatf("%s c%0d vec_cnt", tag, c), 32'(o_vcnt), (drawn < n) ? drawn : n);
      if (last_acc >= 0 && c > last_acc + lat + 3) break;
      if (abort_after > 0 && drawn == abort_after) begin
        set_valid(s, 1'b0);
        return;
      end
      if (drawn < n_drive && ($urandom_range(0, 3) != 0 || c > 40)) begin
        k = drawn;
        qv[c] = 1'b1;
        if (mode == 4) begin
          qa[c] = 0; qb[c] = 0; qc[c] = 0;
        end else if (exh) begin
          qa[c] = 3'((k >> 2) & 1); qb[c] = 3'((k >> 1) & 1); qc[c] = 1'(k & 1);
        end else begin
          qa[c] = 3'($urandom_range(0, (1 << w) - 1));
          qb[c] = 3'($urandom_range(0, (1 << w) - 1));
          qc[c] = 1'($urandom);
        end
        golden = int'(qa[c]) + int'(qb[c]) + int'(qc[c]);
        case (mode)
          1:       mask = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (1 << (w + 1)) - 1)) : 0;
          2:       mask = int'($urandom_range(1, (1 << (w + 1)) - 1));
          3:       mask = (k == 7) ? (1 << w) : 0;
          default: mask = 0;
        endcase
        qr[c] = 4'(golden ^ mask);
        if (k < n) begin
          if (int'(qr[c]) != golden) begin
            mism++;
            if (!exp_ffv) begin exp_ffv = 1; exp_ffi = k; end
          end
          idx = (int'(qa[c]) << (w + 1)) | (int'(qb[c]) << 1) | int'(qc[c]);
          if (!seen[idx]) begin seen[idx] = 1; nseen++; end
          if (k == n - 1) last_acc = c;
        end
        drawn++;
        set_valid(s, 1'b1);
        a_s = qa[c]; b_s = qb[c]; cin_s = qc[c];
      end else begin
        qv[c] = 1'b0;
        set_valid(s, (last_acc >= 0) ? 1'($urandom) : 1'b0);
        a_s = 3'($urandom); b_s = 3'($urandom); cin_s = 1'($urandom);
      end
      if (c >= lat && qv[c - lat]) res_s = qr[c - lat];
      else res_s = 4'($urandom);
      @(negedge clk);
    end
    set_valid(s, 1'b0);
`ifdef ADDER_CHK_COVER_EN
    exp_cov = (nseen == (1 << (2 * w + 1)));
`else
    exp_cov = 1'b1;
`endif
    check_final(tag, 0, 1, int'(mism == 0 && exp_cov), (mism < emax) ? mism : emax, n,
                int'(exp_ffv), exp_ffi, int'(exp_cov));
  endtask

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0;
    a_s = 0; b_s = 0; cin_s = 0; res_s = 0; sel = 0;
    do_reset("por");

    // Vectors in IDLE are ignored.
    sel = 0;
    @(negedge clk);
    valid_a = 1; a_s = 1; b_s = 1; cin_s = 1; res_s = 0;
    @(negedge clk);
    @(negedge clk);
    valid_a = 0;
    check_final("idle_vec", 0, 0, 0, 0, 0, 0, 0, COV_RST);

    run_session("a_exh",    0, 8,  0, 1, 0);
    run_session("a_v7",     0, 8,  3, 1, 0);
    run_session("a_rnd",    0, 10, 1, 0, 0);
    run_session("a_zero",   0, 8,  4, 0, 0);
    run_session("b_clean",  1, 18, 0, 0, 0);
    run_session("b_sat",    1, 16, 2, 0, 0);
    run_session("b_abort",  1, 16, 2, 0, 4);
    run_session("b_after",  1, 16, 0, 0, 0);
    run_session("a_abort",  0, 8,  2, 0, 4);
    run_session("a_after",  0, 8,  0, 1, 0);
    run_session("a_abort2", 0, 8,  2, 0, 5);
    do_reset("rst_a");
    run_session("b_abort2", 1, 16, 1, 0, 6);
    do_reset("rst_b");
    run_session("a_rnd2",   0, 12, 1, 0, 0);
    run_session("b_rnd",    1, 16, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
